ldst_exec_unit: RTL

Parametrised load/store execution unit; the next-generation CPU core datapath for the memory subsystem (cache transparent to the core).
- Accepts one instruction at a time over a valid/ready handshake.
- Executes LD/ST/LDI/STI/NOP against an internal register file and a handshaked memory port.
- Reports a sticky error code, including a memory-timeout error the previous core lacked.

---
 rtl/ldst_exec_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ldst_exec_unit.sv
// Load/store execution unit: one instruction at a time, internal register file, handshaked memory port.
// Sticky error reporting, including memory timeout; only reset leaves the error state.
module ldst_exec_unit #(
  parameter int INSTRUCTIONWIDTH = 32,
  parameter int WORDWIDTH        = 32,
  parameter int ADDRWIDTH        = 16,
  parameter int NREGS            = 8,
  parameter int TIMEOUT          = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        instrValid,
  input  logic [INSTRUCTIONWIDTH-1:0] instruction,
  output logic                        instrReady,
  output logic                        done,
  input  logic [3:0]                  dbgIdx,
  output logic [WORDWIDTH-1:0]        dataOut,
  input  logic                        rdEn,
  input  logic                        wtEn,
  input  logic [WORDWIDTH-1:0]        dataFromMem,
  output logic [1:0]                  rwToMem,
  output logic [ADDRWIDTH-1:0]        addrToMem,
  output logic [WORDWIDTH-1:0]        dataToMem,
  output logic [1:0]                  errReg
);

  localparam int OPW = INSTRUCTIONWIDTH - 8;
  localparam int IW  = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam logic [4:0] NREGS_W = 5'(NREGS);

  localparam logic [3:0] OP_NOP = 4'd0, OP_LD = 4'd1, OP_ST = 4'd2, OP_LDI = 4'd3, OP_STI = 4'd4;
  localparam logic [1:0] MEM_IDLE = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2;
  localparam logic [1:0] NOERR = 2'd0, ERR_CPUOP = 2'd1, ERR_TIMEOUT = 2'd2, ERR_REG = 2'd3;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, ERROR} state_t;

  state_t                 state, state_nxt;
  logic [WORDWIDTH-1:0]   regs [NREGS];
  logic [IW-1:0]          ld_reg;
  logic [CW-1:0]          tcnt;

  logic [3:0]             op, rd;
  logic [OPW-1:0]         operand;
  logic [IW-1:0]          rd_idx;
  logic [ADDRWIDTH-1:0]   addr;
  logic [WORDWIDTH-1:0]   imm, sti_imm;
  logic                   accept, op_illegal, reg_bad, timeout_hit;

  assign op          = instruction[INSTRUCTIONWIDTH-1 -: 4];
  assign rd          = instruction[INSTRUCTIONWIDTH-5 -: 4];
  assign operand     = instruction[OPW-1:0];
  assign rd_idx      = rd[IW-1:0];
  assign addr        = operand[ADDRWIDTH-1:0];
  assign imm         = WORDWIDTH'(operand);
  // STI carries its immediate in the operand bits above the address field
  assign sti_imm     = WORDWIDTH'(operand >> ADDRWIDTH);
  assign accept      = instrValid && instrReady;
  assign op_illegal  = (op > OP_STI);
  assign reg_bad     = (op == OP_LD || op == OP_ST || op == OP_LDI) && ({1'b0, rd} >= NREGS_W);
  assign timeout_hit = (tcnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op_illegal || reg_bad)           state_nxt = ERROR;
          else if (op == OP_LD)                state_nxt = RD_WAIT;
          else if (op == OP_ST || op == OP_STI) state_nxt = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (rdEn)             state_nxt = IDLE;
        else if (timeout_hit) state_nxt = ERROR;
      end
      WR_WAIT: begin
        if (wtEn)             state_nxt = IDLE;
        else if (timeout_hit) state_nxt = ERROR;
      end
      default: state_nxt = ERROR;
    endcase
  end

  always_comb begin
    instrReady = (state == IDLE);
    dataOut    = '0;
    if ({1'b0, dbgIdx} < NREGS_W) dataOut = regs[dbgIdx[IW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      rwToMem   <= MEM_IDLE;
      addrToMem <= '0;
      dataToMem <= '0;
      done      <= 1'b0;
      errReg    <= NOERR;
      tcnt      <= '0;
      ld_reg    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_illegal)   errReg <= ERR_CPUOP;
            else if (reg_bad) errReg <= ERR_REG;
            else begin
              case (op)
                OP_NOP: done <= 1'b1;
                OP_LDI: begin
                  regs[rd_idx] <= imm;
                  done         <= 1'b1;
                end
                OP_LD: begin
                  rwToMem   <= MEM_READ;
                  addrToMem <= addr;
                  ld_reg    <= rd_idx;
                  tcnt      <= '0;
                end
                OP_ST, OP_STI: begin
                  rwToMem   <= MEM_WRITE;
                  addrToMem <= addr;
                  dataToMem <= (op == OP_ST) ? regs[rd_idx] : sti_imm;
                  tcnt      <= '0;
                end
                default: ;
              endcase
            end
          end
        end
        RD_WAIT: begin
          // an enable on the expiry edge still completes normally
          if (rdEn) begin
            regs[ld_reg] <= dataFromMem;
            rwToMem      <= MEM_IDLE;
            done         <= 1'b1;
          end else if (timeout_hit) begin
            errReg  <= ERR_TIMEOUT;
            rwToMem <= MEM_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WR_WAIT: begin
          if (wtEn) begin
            rwToMem <= MEM_IDLE;
            done    <= 1'b1;
          end else if (timeout_hit) begin
            errReg  <= ERR_TIMEOUT;
            rwToMem <= MEM_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: rwToMem <= MEM_IDLE;
      endcase
    end
  end

endmodule
